// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the 5-stage MIPS pipeline.
// Holds the IF/ID register layout used by fetch, decode and the hazard unit,
// plus the fetch-stage action/mode encodings and the word-alignment helper.
package pipe_pkg;

    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
    localparam logic [31:0] CNT_MAX       = 32'hFFFF_FFFF;

    // IF/ID pipeline register contents
    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
    } ifid_t;

    // Fetch mode, derived directly from the run enable
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } if_state_e;

    // What the fetch stage does on the coming edge
    typedef enum logic [1:0] {
        ACT_IDLE  = 2'd0,
        ACT_STALL = 2'd1,
        ACT_FLUSH = 2'd2,
        ACT_FETCH = 2'd3
    } if_act_e;

    // Instructions are word aligned; low two address bits are dropped
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_pc_reg.sv
// PC register with hold / load-target / increment-by-4 and target alignment.
// Latency: pc_o updates one edge after the control inputs; pc4_o is combinational.
// Backpressure: hold_i freezes the PC; hold has priority over load.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset (PC <- RESET_PC)
//   hold_i           keep current PC
//   load_i           load aligned target_i
//   target_i [31:0]  redirect address (bits [1:0] ignored)
//   pc_o     [31:0]  current PC
//   pc4_o    [31:0]  PC + 4, modulo 2^32
module if_pc_reg
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        hold_i,
    input  logic        load_i,
    input  logic [31:0] target_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc4_o
);

    logic [31:0] r_pc;
    logic [31:0] w_pc4;
    logic [31:0] w_pc_nxt;

    // Wraps naturally at 32 bits: FFFF_FFFC + 4 = 0
    assign w_pc4 = r_pc + 32'd4;

    always_comb begin
        w_pc_nxt = w_pc4;
        if (hold_i) begin
            w_pc_nxt = r_pc;
        end else if (load_i) begin
            w_pc_nxt = align_word(target_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_nxt;
        end
    end

    assign pc_o  = r_pc;
    assign pc4_o = w_pc4;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, branch redirect, imem address, IF/ID register.
// Latency: instruction at imem_addr_o appears on ifid_instr_o after one edge.
// Backpressure: stall_i holds PC and IF/ID; start_i=0 holds PC and drains IF/ID.
// Optional macro IF_STAGE_PERF_EN adds stall/flush/fetch saturating counters.
// Ports:
//   clk_i, rst_i                       clock, synchronous active-high reset
//   start_i                            run enable
//   stall_i                            load-use stall from hazard unit
//   branch_taken_i, branch_target_i    redirect request from ID
//   imem_instr_i / imem_addr_o         combinational instruction memory
//   ifid_pc4_o, ifid_instr_o, ifid_valid_o   IF/ID register outputs
//   stall_cnt_o, flush_cnt_o, fetch_cnt_o    perf counters (IF_STAGE_PERF_EN only)
module if_stage
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic [31:0] imem_instr_i,
    output logic [31:0] imem_addr_o,
    output logic [31:0] ifid_pc4_o,
    output logic [31:0] ifid_instr_o,
`ifdef IF_STAGE_PERF_EN
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o,
    output logic [31:0] fetch_cnt_o,
`endif
    output logic        ifid_valid_o
);

    if_state_e w_state;
    if_act_e   w_act;
    logic      w_pc_hold;
    logic      w_pc_load;
    logic [31:0] w_pc;
    logic [31:0] w_pc4;
    ifid_t     r_ifid;
    ifid_t     w_ifid_nxt;
    ifid_t     w_bubble;

    assign w_bubble = '{pc4: 32'd0, instr: NOP_INSTR, valid: 1'b0};

    // Mode and per-edge action, priority: idle > stall > branch > fetch.
    // A branch seen during a stall is dropped; the hazard unit re-asserts it.
    always_comb begin
        w_state   = start_i ? ST_RUN : ST_IDLE;
        w_act     = ACT_FETCH;
        w_pc_hold = 1'b0;
        w_pc_load = 1'b0;
        if (w_state == ST_IDLE) begin
            w_act     = ACT_IDLE;
            w_pc_hold = 1'b1;
        end else if (stall_i) begin
            w_act     = ACT_STALL;
            w_pc_hold = 1'b1;
        end else if (branch_taken_i) begin
            w_act     = ACT_FLUSH;
            w_pc_load = 1'b1;
        end
    end

    if_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .hold_i   (w_pc_hold),
        .load_i   (w_pc_load),
        .target_i (branch_target_i),
        .pc_o     (w_pc),
        .pc4_o    (w_pc4)
    );

    always_comb begin
        w_ifid_nxt = r_ifid;
        case (w_act)
            ACT_IDLE:  w_ifid_nxt = w_bubble;
            ACT_STALL: w_ifid_nxt = r_ifid;
            ACT_FLUSH: w_ifid_nxt = w_bubble; // squash wrong-path fetch
            ACT_FETCH: w_ifid_nxt = '{pc4: w_pc4, instr: imem_instr_i, valid: 1'b1};
            default:   w_ifid_nxt = w_bubble;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ifid <= w_bubble;
        end else begin
            r_ifid <= w_ifid_nxt;
        end
    end

    assign imem_addr_o  = w_pc;
    assign ifid_pc4_o   = r_ifid.pc4;
    assign ifid_instr_o = r_ifid.instr;
    assign ifid_valid_o = r_ifid.valid;

`ifdef IF_STAGE_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;
    logic [31:0] r_fetch_cnt;

    // Counters only advance in RUN; IDLE edges never map to these actions
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
            r_fetch_cnt <= 32'd0;
        end else begin
            if (w_act == ACT_STALL && r_stall_cnt != CNT_MAX) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_act == ACT_FLUSH && r_flush_cnt != CNT_MAX) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
            if (w_act == ACT_FETCH && r_fetch_cnt != CNT_MAX) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
    assign fetch_cnt_o = r_fetch_cnt;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, sequential fetch, stall, branch,
// stall-over-branch, PC wrap, start drop/resume, mid-run reset.
// Instruction memory is a small combinational model inside the bench.
module tb_if_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        stall_i;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;
    logic [31:0] imem_instr_i;
    logic [31:0] imem_addr_o;
    logic [31:0] ifid_pc4_o;
    logic [31:0] ifid_instr_o;
    logic        ifid_valid_o;
`ifdef IF_STAGE_PERF_EN
    logic [31:0] stall_cnt_o;
    logic [31:0] flush_cnt_o;
    logic [31:0] fetch_cnt_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    // Memory model: address 0 holds addi, every other word is 8C00_0000 ^ addr
    assign imem_instr_i = (imem_addr_o == 32'd0) ? 32'h2002_0005
                                                 : (32'h8C00_0000 ^ imem_addr_o);

    if_stage dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .stall_i         (stall_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .imem_instr_i    (imem_instr_i),
        .imem_addr_o     (imem_addr_o),
        .ifid_pc4_o      (ifid_pc4_o),
        .ifid_instr_o    (ifid_instr_o),
`ifdef IF_STAGE_PERF_EN
        .stall_cnt_o     (stall_cnt_o),
        .flush_cnt_o     (flush_cnt_o),
        .fetch_cnt_o     (fetch_cnt_o),
`endif
        .ifid_valid_o    (ifid_valid_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_if(input string tag, input logic [31:0] addr,
                          input logic [31:0] pc4, input logic [31:0] instr,
                          input logic valid);
        chk({tag, ".addr"},  imem_addr_o, addr);
        chk({tag, ".pc4"},   ifid_pc4_o, pc4);
        chk({tag, ".instr"}, ifid_instr_o, instr);
        chk({tag, ".valid"}, {31'd0, ifid_valid_o}, {31'd0, valid});
    endtask

    // Advance one edge and sample away from it
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; stall_i = 1'b0;
        branch_taken_i = 1'b0; branch_target_i = 32'd0;
        #1;
        tick(); tick();
        chk_if("reset", 32'h0, 32'h0, 32'h0, 1'b0);
`ifdef IF_STAGE_PERF_EN
        chk("reset.fetch_cnt", fetch_cnt_o, 32'd0);
`endif

        rst_i = 1'b0; start_i = 1'b1;
        chk("pre_fetch.addr", imem_addr_o, 32'h0);
        tick(); chk_if("fetch0", 32'h4, 32'h4, 32'h2002_0005, 1'b1);
        tick(); chk_if("fetch4", 32'h8, 32'h8, 32'h8C00_0004, 1'b1);

        // Load-use stall at PC=8 for two edges
        stall_i = 1'b1;
        tick(); chk_if("stall1", 32'h8, 32'h8, 32'h8C00_0004, 1'b1);
        tick(); chk_if("stall2", 32'h8, 32'h8, 32'h8C00_0004, 1'b1);
        stall_i = 1'b0;
        tick(); chk_if("resume8", 32'hC, 32'hC, 32'h8C00_0008, 1'b1);

        // Branch under stall is ignored
        stall_i = 1'b1; branch_taken_i = 1'b1; branch_target_i = 32'h0000_0043;
        tick(); chk_if("stall_br", 32'hC, 32'hC, 32'h8C00_0008, 1'b1);
        stall_i = 1'b0;
        tick(); chk_if("branch", 32'h40, 32'h0, 32'h0, 1'b0);
        branch_taken_i = 1'b0;
        tick(); chk_if("fetch40", 32'h44, 32'h44, 32'h8C00_0040, 1'b1);
`ifdef IF_STAGE_PERF_EN
        chk("perf1.fetch", fetch_cnt_o, 32'd4);
        chk("perf1.stall", stall_cnt_o, 32'd3);
        chk("perf1.flush", flush_cnt_o, 32'd1);
`endif

        // Wrap: jump to top word, then step past 2^32
        branch_taken_i = 1'b1; branch_target_i = 32'hFFFF_FFFF;
        tick(); chk_if("br_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
        branch_taken_i = 1'b0;
        tick(); chk_if("wrap", 32'h0, 32'h0, 32'h73FF_FFFC, 1'b1);

        // Move to 0x20, then drop start for three edges
        branch_taken_i = 1'b1; branch_target_i = 32'h0000_0020;
        tick(); chk_if("br20", 32'h20, 32'h0, 32'h0, 1'b0);
        branch_taken_i = 1'b0; start_i = 1'b0;
        tick(); chk_if("idle1", 32'h20, 32'h0, 32'h0, 1'b0);
        stall_i = 1'b1;
        tick(); chk_if("idle2", 32'h20, 32'h0, 32'h0, 1'b0);
        stall_i = 1'b0;
        tick(); chk_if("idle3", 32'h20, 32'h0, 32'h0, 1'b0);
        start_i = 1'b1;
        tick(); chk_if("resume20", 32'h24, 32'h24, 32'h8C00_0020, 1'b1);
`ifdef IF_STAGE_PERF_EN
        chk("perf2.fetch", fetch_cnt_o, 32'd6);
        chk("perf2.stall", stall_cnt_o, 32'd3);
        chk("perf2.flush", flush_cnt_o, 32'd3);
`endif

        // Reset overrides stall, branch and start on the same edge
        rst_i = 1'b1; stall_i = 1'b1; branch_taken_i = 1'b1; branch_target_i = 32'h100;
        tick(); chk_if("midrst", 32'h0, 32'h0, 32'h0, 1'b0);
`ifdef IF_STAGE_PERF_EN
        chk("midrst.fetch", fetch_cnt_o, 32'd0);
        chk("midrst.stall", stall_cnt_o, 32'd0);
        chk("midrst.flush", flush_cnt_o, 32'd0);
`endif
        rst_i = 1'b0; stall_i = 1'b0; branch_taken_i = 1'b0;
        tick(); chk_if("post_rst", 32'h4, 32'h4, 32'h2002_0005, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage for the 5-stage MIPS pipeline.
- Owns the PC register and the PC+4 incrementer, selects the branch redirect, and drives the instruction-memory address.
- Captures the fetched instruction into the IF/ID pipeline register that feeds decode (Control, Registers, Sign_Extend).
- Supports load-use stalls and branch flushes from the hazard unit.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word injected into IF/ID on a bubble.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  run enable; PC and IF/ID hold while low
- stall_i  in  1  load-use stall from the hazard unit
- branch_taken_i  in  1  branch resolved taken in ID; redirect PC and flush IF/ID
- branch_target_i  in  32  branch target address
- imem_instr_i  in  32  instruction from Instruction_Memory (combinational read)
- imem_addr_o  out  32  current PC, to Instruction_Memory
- ifid_pc4_o  out  32  registered PC+4 of the instruction in IF/ID
- ifid_instr_o  out  32  registered instruction
- ifid_valid_o  out  1  1 = IF/ID holds a real instruction; 0 = bubble

Behaviour:
- All state updates on the rising edge of clk_i.
- Reset: when rst_i=1 at an edge:
  - PC = RESET_PC
  - ifid_pc4_o = 0
  - ifid_instr_o = NOP_INSTR
  - ifid_valid_o = 0
- imem_addr_o equals the PC register, combinationally. Fetch latency is 1 cycle: the instruction at PC appears on ifid_instr_o after the next edge.
- PC+4 arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000. No overflow flag.
- branch_target_i[1:0] is ignored; the loaded PC is {branch_target_i[31:2], 2'b00}.
- Per-edge priority, highest first (reset excluded):
  1. start_i=0 (IDLE): PC holds; IF/ID loads a bubble (NOP_INSTR, valid=0, pc4=0).
  2. stall_i=1: PC holds; IF/ID holds all fields. branch_taken_i is ignored this cycle; the hazard unit re-asserts it when the stall clears.
  3. branch_taken_i=1: PC = aligned target; IF/ID loads a bubble, squashing the wrong-path fetch.
  4. Otherwise: PC = PC+4; ifid_instr_o = imem_instr_i, ifid_pc4_o = PC+4, ifid_valid_o = 1.
- Two states, derived from start_i:
  - IDLE (start_i=0): no fetch progress.
  - RUN (start_i=1): fetch as above.
  - Dropping start_i mid-run freezes the PC and drains IF/ID to a bubble. Raising start_i resumes from the held PC, with no instruction lost or duplicated.
- Reset asserted mid-operation overrides stall, branch and start on the same edge.
- Outputs are never X after the first reset edge.

Optional Feature:
- Macro IF_STAGE_PERF_EN.
- When defined, adds three outputs:
  - stall_cnt_o [31:0]: counts edges where priority 2 applies.
  - flush_cnt_o [31:0]: counts edges where priority 3 applies.
  - fetch_cnt_o [31:0]: counts edges where priority 4 applies.
- All counters are cleared by rst_i, saturate at 32'hFFFF_FFFF, and do not count while start_i=0.
- When not defined: ports and logic are absent; the remaining behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - constants RESET_PC_DEF and NOP_INSTR_DEF
  - typedef ifid_t {pc4[31:0], instr[31:0], valid}, reused by later IF/ID consumers and by the hazard unit.
- One natural sub-module: if_pc_reg, the PC register with hold/load/increment and the alignment mask.
- The IF/ID register and the perf counters stay in if_stage.

Test Plan:
- Reset: rst_i=1 for 2 cycles, then start_i=1 with imem returning 32'h2002_0005 at address 0 -> imem_addr_o=0; after the next edge, ifid_instr_o=32'h2002_0005, ifid_pc4_o=4, ifid_valid_o=1, and PC=4.
- Sequential fetch: 4 run cycles from PC=0 -> imem_addr_o steps 0,4,8,C,10; ifid_pc4_o steps 4,8,C,10.
- Stall: stall_i=1 for 2 cycles at PC=8 -> imem_addr_o stays 8; IF/ID holds the instruction from address 4; fetch resumes with address 8 after stall_i drops.
- Branch: at PC=C, branch_taken_i=1 with target 32'h0000_0043 -> PC becomes 32'h40; IF/ID becomes NOP with valid=0; next fetch is from 0x40. Same edge with stall_i=1 -> branch ignored and PC stays C.
- Wrap and start: PC=32'hFFFF_FFFC, normal step -> PC=0. start_i dropped at PC=0x20 for 3 cycles -> PC holds 0x20 and ifid_valid_o=0; resumes at 0x20.
- Perf (IF_STAGE_PERF_EN): 5 fetches, 2 stalls, 1 flush -> fetch_cnt_o=5, stall_cnt_o=2, flush_cnt_o=1. rst_i mid-run -> all counters 0 and PC=RESET_PC on the same edge.
